mem_access_unit: RTL

Requester side of the data-memory port. Accepts byte, half, word and doubleword load/store requests from the datapath over a valid/ready handshake, and drives the data memory's `address` / `WE` / `dIn` inputs. Captures `data_out` for loads, performs read-modify-write for sub-doubleword stores, and returns one response pulse per request. Sits between the processor datapath and the 32 × 64-bit data memory.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory requester.
// Size codes, FSM states and the alignment rule.
package mem_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } st_e;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [2:0] offset
  );
    logic mis;
    unique case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath-side request/response handshake of the memory unit.
// master = datapath, slave = mem_access_unit.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+2:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and
// lane merge for sub-doubleword stores.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [2:0]        off,
  input  logic              uns,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] merged
);

  logic [5:0]        sh;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] mask;
  logic              sx;

  assign sh   = {off, 3'b000};
  assign lane = old >> sh;
  assign sx   = ~uns;

  always_comb begin
    rdata = lane;
    mask  = '1;
    unique case (size)
      SZ_B: begin
        rdata = {{(DATA_W-8){sx & lane[7]}}, lane[7:0]};
        mask  = {{(DATA_W-8){1'b0}}, 8'hFF};
      end
      SZ_H: begin
        rdata = {{(DATA_W-16){sx & lane[15]}}, lane[15:0]};
        mask  = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      end
      SZ_W: begin
        rdata = {{(DATA_W-32){sx & lane[31]}}, lane[31:0]};
        mask  = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        rdata = lane;
        mask  = '1;
      end
    endcase
    merged = (old & ~(mask << sh)) | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Requester for the 32 x 64-bit data memory: one request in
// flight, read-modify-write for narrow stores, one response pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  req,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_WE,
  output logic [DATA_W-1:0] mem_dIn,
  input  logic [DATA_W-1:0] mem_dout
);

  st_e state, state_n;

  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+2:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] din_hold;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              mis_in;

  assign accept = req.req_valid & req.req_ready;
  assign mis_in = is_misaligned(req.req_size, req.req_addr[2:0]);

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .old    (old_q),
    .wdata  (wdata_q),
    .size   (size_q),
    .off    (addr_q[2:0]),
    .uns    (uns_q),
    .rdata  (ext),
    .merged (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n         = state;
    req.req_ready   = 1'b0;
    req.resp_valid  = 1'b0;
    req.resp_err    = 1'b0;
    req.resp_rdata  = '0;
    mem_WE          = 1'b0;
    mem_address     = addr_hold;
    mem_dIn         = din_hold;
    unique case (state)
      IDLE: begin
        req.req_ready = ~reset;
        if (accept) begin
          if (mis_in)
            state_n = RESP;
          else if (req.req_we && req.req_size == SZ_D)
            state_n = WRITE;
          else
            state_n = READ;
        end
      end
      READ: begin
        mem_address = addr_q[ADDR_W+2:3];
        state_n     = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_address = addr_q[ADDR_W+2:3];
        mem_WE      = 1'b1;
        mem_dIn     = merged;
        state_n     = RESP;
      end
      default: begin
        req.resp_valid = 1'b1;
        req.resp_err   = err_q;
        if (!we_q && !err_q) req.resp_rdata = ext;
        state_n = IDLE;
      end
    endcase
  end

  // Address/data hold registers keep the memory bus quiet between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      old_q     <= '0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req.req_we;
        uns_q   <= req.req_unsigned;
        err_q   <= mis_in;
        size_q  <= req.req_size;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
      end
      if (state == READ) old_q <= mem_dout;
      if (state == READ || state == WRITE)
        addr_hold <= addr_q[ADDR_W+2:3];
      if (state == WRITE) din_hold <= merged;
    end
  end

endmodule
